nes_controller_reader: RTL and testbench

//  Console-side master for the NES serial controller interface. Generates the

---
 rtl/nes_pkg.sv | 29 ++
 rtl/nes_tick_timer.sv | 33 +++
 rtl/nes_controller_reader.sv | 158 +++++++++++++++
 tb/tb_nes_controller_reader.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/nes_pkg.sv
// Shared definitions for the NES controller reader.
//   nes_rd_state_t : read sequencer states
//   BTN_*          : bit positions of each button in the published word
//   nes_max        : helper used to size the shared tick timer
package nes_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LATCH  = 3'd1,
    SETTLE = 3'd2,
    CLK_HI = 3'd3,
    CLK_LO = 3'd4,
    DONE   = 3'd5
  } nes_rd_state_t;

  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

  function automatic int nes_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/nes_tick_timer.sv
// Loadable down-counter used to time the latch pulse, the settle gap and
// every nes_clk half-period.
//   clk      in  : system clock
//   reset    in  : asynchronous, active-low
//   load     in  : load load_val this cycle
//   load_val in  : cycles-minus-one the owning state should last
//   done     out : counter has reached zero (last cycle of the interval)
module nes_tick_timer #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  // Loading N-1 on state entry makes done rise in the N-th cycle of the state.
  assign done = (cnt == '0);

endmodule

// File: rtl/nes_controller_reader.sv
// Console-side master for the NES serial controller interface.
// Produces the latch and shift-clock pulses, samples the serial line into an
// 8-bit word (A first, bit0 = A) and publishes it with a one-cycle strobe.
// Reads start on poll_req or from the internal auto-poll timer.
//   clk       in  : system clock
//   reset     in  : asynchronous, active-low
//   poll_req  in  : start one read (ignored while busy)
//   auto_en   in  : enable periodic polling every POLL_PERIOD cycles
//   data_in   in  : serial data from the controller
//   nes_latch out : parallel-load strobe
//   nes_clk   out : shift clock
//   nes_en    out : shift enable, high from LATCH through DONE
//   buttons   out : last complete word {R,L,DN,UP,STRT,SEL,B,A}
//   valid     out : buttons updated this cycle
//   busy      out : a read is in progress
module nes_controller_reader
  import nes_pkg::*;
#(
  parameter int CLK_DIV      = 300,
  parameter int LATCH_CYCLES = 600,
  parameter int POLL_PERIOD  = 833333,
  parameter bit DATA_INV     = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       poll_req,
  input  logic       auto_en,
  input  logic       data_in,
  output logic       nes_latch,
  output logic       nes_clk,
  output logic       nes_en,
  output logic [7:0] buttons,
  output logic       valid,
  output logic       busy
);

  localparam int TW = $clog2(nes_max(CLK_DIV, LATCH_CYCLES) + 1);
  localparam int PW = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
  localparam logic [TW-1:0] LAT_LD  = TW'(LATCH_CYCLES - 1);
  localparam logic [TW-1:0] HALF_LD = TW'(CLK_DIV - 1);
  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_PERIOD - 1);

  nes_rd_state_t   state, state_nx;
  logic [2:0]      idx, samp_idx;
  logic [7:0]      shreg, shreg_nx;
  logic            samp, start;
  logic            tmr_load, tmr_done;
  logic [TW-1:0]   tmr_val;
  logic [PW-1:0]   poll_cnt;
  logic            pending, wrap;

  nes_tick_timer #(.W(TW)) u_tmr (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  always_comb begin
    state_nx = state;
    tmr_load = 1'b0;
    tmr_val  = HALF_LD;
    samp     = 1'b0;
    start    = 1'b0;
    case (state)
      IDLE: begin
        if (poll_req || pending) begin
          state_nx = LATCH;
          tmr_load = 1'b1;
          tmr_val  = LAT_LD;
          start    = 1'b1;
        end
      end
      LATCH: begin
        if (tmr_done) begin
          state_nx = SETTLE;
          tmr_load = 1'b1;
        end
      end
      SETTLE: begin
        if (tmr_done) begin
          samp     = 1'b1;
          state_nx = CLK_HI;
          tmr_load = 1'b1;
        end
      end
      CLK_HI: begin
        if (tmr_done) begin
          state_nx = CLK_LO;
          tmr_load = 1'b1;
        end
      end
      CLK_LO: begin
        if (tmr_done) begin
          samp     = 1'b1;
          tmr_load = 1'b1;
          // idx holds the last bit sampled; bit 7 is the final one.
          state_nx = (idx == 3'd6) ? DONE : CLK_HI;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Bit 0 comes in at the end of SETTLE, bits 1..7 at the end of each CLK_LO.
  assign samp_idx = (state == SETTLE) ? 3'd0 : idx + 3'd1;

  always_comb begin
    shreg_nx = shreg;
    if (samp) shreg_nx[samp_idx] = data_in ^ DATA_INV;
  end

  // Auto-poll wrap; a wrap coinciding with a read start is absorbed by it.
  assign wrap = auto_en && (poll_cnt == POLL_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      poll_cnt <= '0;
      pending  <= 1'b0;
    end else if (!auto_en) begin
      poll_cnt <= '0;
      pending  <= 1'b0;
    end else begin
      poll_cnt <= wrap ? '0 : poll_cnt + 1'b1;
      if (start)     pending <= 1'b0;
      else if (wrap) pending <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      idx       <= 3'd0;
      nes_latch <= 1'b0;
      nes_clk   <= 1'b0;
      nes_en    <= 1'b0;
      busy      <= 1'b0;
      valid     <= 1'b0;
      buttons   <= 8'h00;
    end else begin
      state     <= state_nx;
      if (samp) idx <= samp_idx;
      nes_latch <= (state_nx == LATCH);
      nes_clk   <= (state_nx == CLK_HI);
      nes_en    <= (state_nx != IDLE);
      busy      <= (state_nx != IDLE);
      valid     <= (state_nx == DONE);
      if (state_nx == DONE) buttons <= shreg_nx;
    end
  end

  always_ff @(posedge clk) begin
    shreg <= shreg_nx;
  end

endmodule

// File: tb/tb_nes_controller_reader.sv
module tb_nes_controller_reader;

  localparam int H  = 2;
  localparam int L  = 4;
  localparam int P  = 100;
  localparam int RD = L + 15 * H + 1;

  typedef struct {
    logic [7:0]  word;
    int unsigned cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic poll_req = 1'b0;
  logic auto_en = 1'b0;
  logic [7:0] btn = 8'h00;

  logic d0, d1;
  logic lat0, lat1, nc0, nc1, en0, en1, v0, v1, bz0, bz1;
  logic [7:0] b0, b1;

  logic [7:0] sr0 = 8'hFF, sr1 = 8'hFF;
  logic nc0_q = 1'b0, nc1_q = 1'b0;

  int unsigned cyc = 0;
  int n_chk = 0, n_pass = 0, n_valid = 0;
  exp_t sb[$];
  exp_t e;

  nes_controller_reader #(.CLK_DIV(H), .LATCH_CYCLES(L), .POLL_PERIOD(P), .DATA_INV(1'b0)) dut0 (
    .clk(clk), .reset(reset), .poll_req(poll_req), .auto_en(auto_en), .data_in(d0),
    .nes_latch(lat0), .nes_clk(nc0), .nes_en(en0), .buttons(b0), .valid(v0), .busy(bz0)
  );

  nes_controller_reader #(.CLK_DIV(H), .LATCH_CYCLES(L), .POLL_PERIOD(P), .DATA_INV(1'b1)) dut1 (
    .clk(clk), .reset(reset), .poll_req(poll_req), .auto_en(auto_en), .data_in(d1),
    .nes_latch(lat1), .nes_clk(nc1), .nes_en(en1), .buttons(b1), .valid(v1), .busy(bz1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Controller far ends: load while latched, shift on each nes_clk rise.
  // The second one drives the line active-low.
  always @(posedge clk) begin
    if (lat0) sr0 <= btn;
    else if (nc0 && !nc0_q) sr0 <= {1'b1, sr0[7:1]};
    nc0_q <= nc0;
    if (lat1) sr1 <= btn;
    else if (nc1 && !nc1_q) sr1 <= {1'b1, sr1[7:1]};
    nc1_q <= nc1;
  end
  assign d0 = sr0[0];
  assign d1 = ~sr1[0];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // Monitor: pulse shape and scoreboard comparison on every valid strobe.
  logic pclk = 1'b0;
  int hi_len = 0, pulses = 0;
  always @(negedge clk) begin
    if (!reset) begin
      pclk = 1'b0; hi_len = 0; pulses = 0;
    end else begin
      if (lat0) pulses = 0;
      if (nc0) begin
        if (!pclk) pulses++;
        hi_len++;
      end else if (pclk) begin
        check("clk_hi_len", hi_len, H);
        hi_len = 0;
      end
      pclk = nc0;
      if (v0) begin
        n_valid++;
        check("inv_valid", v1, 1);
        check("inv_buttons", b1, b0);
        check("clk_pulses", pulses, 7);
        if (sb.size() == 0) begin
          check("sb_has_entry", sb.size(), 1);
        end else begin
          e = sb.pop_front();
          check("buttons", b0, e.word);
          check("valid_cyc", cyc, e.cyc);
        end
      end else if (v1) begin
        check("inv_valid_extra", v1, v0);
      end
    end
  end

  task automatic poll(input logic [7:0] w);
    btn = w;
    @(negedge clk);
    poll_req = 1'b1;
    sb.push_back('{w, cyc + RD});
    @(negedge clk);
    poll_req = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    while (sb.size() != 0 && k < 300) begin
      @(negedge clk);
      k++;
    end
    check("sb_drain", sb.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int unsigned t, c;
    int nv;
    logic [7:0] pats [4];
    pats[0] = 8'h00; pats[1] = 8'hFF; pats[2] = 8'hA5; pats[3] = 8'h5A;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_outs0", {lat0, nc0, en0, v0, bz0, b0}, 0);
    check("rst_outs1", {lat1, nc1, en1, v1, bz1, b1}, 0);
    reset = 1'b1;
    repeat (3) @(negedge clk);

    // Loopback A, UP, R with busy window
    btn = 8'h91;
    @(negedge clk);
    t = cyc;
    check("busy_T", bz0, 0);
    poll_req = 1'b1;
    sb.push_back('{8'h91, t + RD});
    @(negedge clk);
    poll_req = 1'b0;
    check("busy_T1", bz0, 1);
    check("latch_T1", lat0, 1);
    check("en_T1", en0, 1);
    repeat (L - 1) @(negedge clk);
    check("latch_TL", lat0, 1);
    @(negedge clk);
    check("latch_TL1", lat0, 0);
    repeat (RD - L - 1) @(negedge clk);
    check("busy_T35", bz0, 1);
    check("en_T35", en0, 1);
    @(negedge clk);
    check("busy_T36", bz0, 0);
    check("en_T36", en0, 0);
    drain();

    // Busy ignore
    nv = n_valid;
    poll(8'h3C);
    repeat (8) @(negedge clk);
    poll_req = 1'b1;
    @(negedge clk);
    poll_req = 1'b0;
    drain();
    repeat (40) @(negedge clk);
    check("busy_ignore_reads", n_valid - nv, 1);

    // Assorted patterns
    for (int i = 0; i < 4; i++) begin
      poll(pats[i]);
      drain();
    end

    // Reset in the middle of a CLK_HI phase
    poll(8'h77);
    begin
      int k = 0;
      while (!nc0 && k < 100) begin
        @(negedge clk);
        k++;
      end
    end
    check("wait_clk_hi", nc0, 1);
    #1 reset = 1'b0;
    #1;
    check("rst_mid_outs0", {lat0, nc0, en0, v0, bz0, b0}, 0);
    check("rst_mid_outs1", {lat1, nc1, en1, v1, bz1, b1}, 0);
    sb.delete();
    repeat (3) @(negedge clk);
    check("rst_hold_outs", {lat0, nc0, en0, v0, bz0, b0}, 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    poll(8'h77);
    drain();

    // Inputs changed during a read show up on the next read
    poll(8'h0F);
    repeat (10) @(negedge clk);
    btn = 8'hF0;
    drain();
    poll(8'hF0);
    drain();

    // Auto poll for 1000 cycles
    btn = 8'h6B;
    nv = n_valid;
    @(negedge clk);
    c = cyc;
    auto_en = 1'b1;
    for (int k = 0; k < 10; k++) sb.push_back('{8'h6B, c + P + RD + k * P});
    repeat (1000) @(negedge clk);
    auto_en = 1'b0;
    drain();
    repeat (150) @(negedge clk);
    check("auto_reads", n_valid - nv, 10);

    // poll_req in the same cycle as an auto wrap
    btn = 8'hC3;
    nv = n_valid;
    @(negedge clk);
    c = cyc;
    auto_en = 1'b1;
    repeat (P - 1) @(negedge clk);
    poll_req = 1'b1;
    sb.push_back('{8'hC3, cyc + RD});
    @(negedge clk);
    poll_req = 1'b0;
    repeat (90) @(negedge clk);
    auto_en = 1'b0;
    drain();
    repeat (150) @(negedge clk);
    check("collision_reads", n_valid - nv, 1);
    check("sb_final", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
